// File: rtl/sim_demux_pkg.sv
// Shared types and constants for the simulation data demux.
//   tgt_id_t        : 2-bit target ID kept in the outstanding-transaction FIFO
//   TGT_*           : target IDs (0 periph, 1 stack, 2 tcdm, 3 internal regs)
//   EXIT_ADDR       : testbench exit-code virtual register
//   PUTC_ADDR       : testbench putchar virtual register
//   DECODE_ERR_DATA : read data returned for unmapped internal addresses
package sim_demux_pkg;

  typedef logic [1:0] tgt_id_t;

  localparam tgt_id_t TGT_PERIPH = 2'd0;
  localparam tgt_id_t TGT_STACK  = 2'd1;
  localparam tgt_id_t TGT_TCDM   = 2'd2;
  localparam tgt_id_t TGT_INT    = 2'd3;

  localparam logic [31:0] EXIT_ADDR       = 32'h8000_0000;
  localparam logic [31:0] PUTC_ADDR       = 32'h8000_0004;
  localparam logic [31:0] DECODE_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sim_demux_id_fifo.sv
// In-order FIFO of target IDs for outstanding transactions.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din when not full (a push while full is ignored)
//   pop      : drop the head entry when not empty
//   head     : entry at the head of the FIFO
//   full     : DEPTH entries held
//   empty    : no entries held
// Full is a registered-state view, so a pop while full only frees a slot for
// the next cycle.
module sim_demux_id_fifo
  import sim_demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  tgt_id_t din,
  input  logic    pop,
  output tgt_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  tgt_id_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_data_demux.sv
// Demux between the core LSU data port and the simulation targets
// (0 periph/HWPE, 1 stack, 2 tcdm), plus the internal testbench virtual
// registers (exit code, putchar). Responses return in request order using a
// FIFO of target IDs.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   core_*                : core-side request / grant / response
//   tgt_*                 : per-target request, grant, response; broadcast
//                           address, data, active-low write enable, byte enables
//   exit_valid_o/code_o   : sticky exit flag and last exit code written
//   putchar_valid_o/_o    : one-cycle pulse and character per putchar write
//   proto_err_o           : sticky flag for responses arriving out of turn
module sim_data_demux
  import sim_demux_pkg::*;
#(
  parameter int HWPE_ADDR_BASE_BIT = 20,
  parameter int MAX_OUTSTANDING    = 2,
  parameter int NT                 = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_req_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  input  logic                 core_we_i,
  input  logic [3:0]           core_be_i,
  input  logic [31:0]          core_addr_i,
  input  logic [31:0]          core_wdata_i,
  output logic [31:0]          core_rdata_o,
  output logic                 core_err_o,
  output logic [NT-1:0]        tgt_req_o,
  input  logic [NT-1:0]        tgt_gnt_i,
  input  logic [NT-1:0]        tgt_rvalid_i,
  output logic [NT-1:0][31:0]  tgt_add_o,
  output logic [NT-1:0][31:0]  tgt_data_o,
  output logic                 tgt_wen_o,
  output logic [3:0]           tgt_be_o,
  input  logic [NT-1:0][31:0]  tgt_r_data_i,
  output logic                 exit_valid_o,
  output logic [31:0]          exit_code_o,
  output logic                 putchar_valid_o,
  output logic [7:0]           putchar_o,
  output logic                 proto_err_o
);

  tgt_id_t       sel;
  tgt_id_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          go;
  logic          ext_gnt;
  logic          int_accept;
  logic          int_pending;
  logic          int_err;
  logic [31:0]   int_rdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_data;
  logic [NT-1:0] expected;

  always_comb begin
    if (core_addr_i[31:24] == 8'h80)          sel = TGT_INT;
    else if (core_addr_i[HWPE_ADDR_BASE_BIT]) sel = TGT_PERIPH;
    else if (core_addr_i[31:24] == 8'h00)     sel = TGT_STACK;
    else                                      sel = TGT_TCDM;
  end

  // Request / grant. Requests are held off while the ID FIFO is full so
  // every granted transaction has a slot to record its target.
  always_comb begin
    go         = core_req_i & ~rst_i & ~fifo_full;
    tgt_req_o  = '0;
    ext_gnt    = 1'b0;
    core_gnt_o = 1'b0;
    case (sel)
      TGT_PERIPH: begin tgt_req_o[0] = go; ext_gnt = tgt_gnt_i[0]; end
      TGT_STACK:  begin tgt_req_o[1] = go; ext_gnt = tgt_gnt_i[1]; end
      TGT_TCDM:   begin tgt_req_o[2] = go; ext_gnt = tgt_gnt_i[2]; end
      default:    ext_gnt = 1'b0;
    endcase
    if (sel == TGT_INT) core_gnt_o = go & ~int_pending;
    else                core_gnt_o = go & ext_gnt;
  end

  assign int_accept = core_gnt_o & (sel == TGT_INT);

  always_comb begin
    tgt_add_o[0]  = core_addr_i;
    tgt_add_o[1]  = core_addr_i;
    tgt_add_o[2]  = {8'b0, core_addr_i[23:0]};
    tgt_data_o[0] = core_wdata_i;
    tgt_data_o[1] = core_wdata_i;
    tgt_data_o[2] = core_wdata_i;
  end

  assign tgt_wen_o = ~core_we_i;
  assign tgt_be_o  = core_be_i;

  // Response path follows the FIFO head; any target rvalid not expected by
  // the head is dropped and flagged.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    expected  = '0;
    if (!fifo_empty) begin
      case (head)
        TGT_PERIPH: begin expected = 3'b001; rsp_valid = tgt_rvalid_i[0]; rsp_data = tgt_r_data_i[0]; end
        TGT_STACK:  begin expected = 3'b010; rsp_valid = tgt_rvalid_i[1]; rsp_data = tgt_r_data_i[1]; end
        TGT_TCDM:   begin expected = 3'b100; rsp_valid = tgt_rvalid_i[2]; rsp_data = tgt_r_data_i[2]; end
        default:    begin rsp_valid = int_pending; rsp_data = int_rdata; rsp_err = int_err; end
      endcase
    end
  end

  assign core_rvalid_o = rsp_valid & ~rst_i;
  assign core_rdata_o  = core_rvalid_o ? rsp_data : 32'h0;
  assign core_err_o    = core_rvalid_o & rsp_err;

  sim_demux_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (core_gnt_o),
    .din   (sel),
    .pop   (core_rvalid_o),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Internal virtual registers. Read data is captured at accept time; only
  // one internal transaction may be pending, so accept and its pop never
  // coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_pending     <= 1'b0;
      int_err         <= 1'b0;
      int_rdata       <= '0;
      exit_valid_o    <= 1'b0;
      exit_code_o     <= 32'hFFFF_FFFF;
      putchar_valid_o <= 1'b0;
      putchar_o       <= '0;
      proto_err_o     <= 1'b0;
    end else begin
      putchar_valid_o <= 1'b0;
      if (|(tgt_rvalid_i & ~expected)) proto_err_o <= 1'b1;
      if (int_accept) begin
        int_pending <= 1'b1;
        int_err     <= 1'b0;
        int_rdata   <= '0;
        if (core_addr_i == EXIT_ADDR) begin
          if (core_we_i) begin
            exit_code_o  <= core_wdata_i;
            exit_valid_o <= 1'b1;
          end else begin
            int_rdata <= exit_code_o;
          end
        end else if (core_addr_i == PUTC_ADDR) begin
          if (core_we_i) begin
            putchar_valid_o <= 1'b1;
            putchar_o       <= core_wdata_i[7:0];
          end
        end else begin
          int_err   <= 1'b1;
          int_rdata <= DECODE_ERR_DATA;
        end
      end else if (core_rvalid_o && head == TGT_INT) begin
        int_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sim_data_demux.sv
// Directed self-checking bench for sim_data_demux. Inputs change 1 time unit
// after the rising edge; outputs are checked 2 time units later, well before
// the next edge.
module tb_sim_data_demux;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              core_req_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic              core_we_i;
  logic [3:0]        core_be_i;
  logic [31:0]       core_addr_i;
  logic [31:0]       core_wdata_i;
  logic [31:0]       core_rdata_o;
  logic              core_err_o;
  logic [2:0]        tgt_req_o;
  logic [2:0]        tgt_gnt_i;
  logic [2:0]        tgt_rvalid_i;
  logic [2:0][31:0]  tgt_add_o;
  logic [2:0][31:0]  tgt_data_o;
  logic              tgt_wen_o;
  logic [3:0]        tgt_be_o;
  logic [2:0][31:0]  tgt_r_data_i;
  logic              exit_valid_o;
  logic [31:0]       exit_code_o;
  logic              putchar_valid_o;
  logic [7:0]        putchar_o;
  logic              proto_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  sim_data_demux dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_rvalid_o   (core_rvalid_o),
    .core_we_i       (core_we_i),
    .core_be_i       (core_be_i),
    .core_addr_i     (core_addr_i),
    .core_wdata_i    (core_wdata_i),
    .core_rdata_o    (core_rdata_o),
    .core_err_o      (core_err_o),
    .tgt_req_o       (tgt_req_o),
    .tgt_gnt_i       (tgt_gnt_i),
    .tgt_rvalid_i    (tgt_rvalid_i),
    .tgt_add_o       (tgt_add_o),
    .tgt_data_o      (tgt_data_o),
    .tgt_wen_o       (tgt_wen_o),
    .tgt_be_o        (tgt_be_o),
    .tgt_r_data_i    (tgt_r_data_i),
    .exit_valid_o    (exit_valid_o),
    .exit_code_o     (exit_code_o),
    .putchar_valid_o (putchar_valid_o),
    .putchar_o       (putchar_o),
    .proto_err_o     (proto_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    core_req_i   = 1'b0;
    core_we_i    = 1'b0;
    core_be_i    = 4'hF;
    core_addr_i  = '0;
    core_wdata_i = '0;
    tgt_gnt_i    = '0;
    tgt_rvalid_i = '0;
    tgt_r_data_i = '0;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] gnt);
    core_req_i   = 1'b1;
    core_we_i    = we;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    tgt_gnt_i    = gnt;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    #2;
    chk("rst_gnt",        32'(core_gnt_o), 32'd0);
    chk("rst_rvalid",     32'(core_rvalid_o), 32'd0);
    chk("rst_err",        32'(core_err_o), 32'd0);
    chk("rst_rdata",      core_rdata_o, 32'h0);
    chk("rst_exit_valid", 32'(exit_valid_o), 32'd0);
    chk("rst_exit_code",  exit_code_o, 32'hFFFF_FFFF);
    chk("rst_putc_valid", 32'(putchar_valid_o), 32'd0);
    chk("rst_putc",       32'(putchar_o), 32'd0);
    chk("rst_proto",      32'(proto_err_o), 32'd0);

    // Stack read, response one cycle later.
    cyc();
    req(1'b0, 32'h0000_0100, 32'h0, 3'b010);
    #2;
    chk("stk_tgt_req", 32'(tgt_req_o), 32'b010);
    chk("stk_gnt",     32'(core_gnt_o), 32'd1);
    chk("stk_wen",     32'(tgt_wen_o), 32'd1);
    cyc();
    idle();
    tgt_rvalid_i    = 3'b010;
    tgt_r_data_i[1] = 32'h1234_5678;
    #2;
    chk("stk_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("stk_rdata",  core_rdata_o, 32'h1234_5678);
    chk("stk_err",    32'(core_err_o), 32'd0);
    cyc();
    idle();
    #2;
    chk("stk_rvalid_done", 32'(core_rvalid_o), 32'd0);
    chk("stk_proto",       32'(proto_err_o), 32'd0);

    // Out-of-order periph response is dropped and flagged.
    cyc();
    req(1'b0, 32'h1000_0000, 32'h0, 3'b100);
    #2;
    chk("ooo_tcdm_req", 32'(tgt_req_o), 32'b100);
    chk("ooo_tcdm_add", tgt_add_o[2], 32'h0000_0000);
    cyc();
    req(1'b0, 32'h0010_0000, 32'h0, 3'b001);
    #2;
    chk("ooo_per_req", 32'(tgt_req_o), 32'b001);
    chk("ooo_per_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    idle();
    tgt_rvalid_i    = 3'b001;
    tgt_r_data_i[0] = 32'hAAAA_0000;
    #2;
    chk("ooo_per_rvalid", 32'(core_rvalid_o), 32'd0);
    cyc();
    idle();
    tgt_rvalid_i    = 3'b100;
    tgt_r_data_i[2] = 32'hCCCC_0002;
    #2;
    chk("ooo_proto",      32'(proto_err_o), 32'd1);
    chk("ooo_tcdm_rdata", core_rdata_o, 32'hCCCC_0002);
    do_reset();
    #2;
    chk("ooo_proto_clr", 32'(proto_err_o), 32'd0);

    // Conforming in-order run.
    cyc();
    req(1'b0, 32'h1000_0000, 32'h0, 3'b100);
    cyc();
    req(1'b0, 32'h0010_0000, 32'h0, 3'b001);
    cyc();
    idle();
    cyc();
    tgt_rvalid_i    = 3'b100;
    tgt_r_data_i[2] = 32'hCCCC_0003;
    #2;
    chk("ino_tcdm_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("ino_tcdm_rdata",  core_rdata_o, 32'hCCCC_0003);
    cyc();
    idle();
    tgt_rvalid_i    = 3'b001;
    tgt_r_data_i[0] = 32'hAAAA_0004;
    #2;
    chk("ino_per_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("ino_per_rdata",  core_rdata_o, 32'hAAAA_0004);
    cyc();
    idle();
    #2;
    chk("ino_proto", 32'(proto_err_o), 32'd0);

    // FIFO full: third request stalls until a slot is freed.
    cyc();
    req(1'b0, 32'h0000_0200, 32'h0, 3'b010);
    cyc();
    req(1'b0, 32'h0000_0204, 32'h0, 3'b010);
    cyc();
    req(1'b0, 32'h0000_0208, 32'h0, 3'b010);
    #2;
    chk("full_gnt0", 32'(core_gnt_o), 32'd0);
    chk("full_req0", 32'(tgt_req_o), 32'b000);
    cyc();
    #2;
    chk("full_gnt1", 32'(core_gnt_o), 32'd0);
    cyc();
    tgt_rvalid_i    = 3'b010;
    tgt_r_data_i[1] = 32'h0000_0A00;
    #2;
    chk("full_pop_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("full_pop_gnt",    32'(core_gnt_o), 32'd0);
    cyc();
    tgt_rvalid_i = 3'b000;
    #2;
    chk("full_gnt_after", 32'(core_gnt_o), 32'd1);
    cyc();
    idle();
    tgt_rvalid_i    = 3'b010;
    tgt_r_data_i[1] = 32'h0000_0A04;
    #2;
    chk("full_rdata2", core_rdata_o, 32'h0000_0A04);
    cyc();
    tgt_rvalid_i    = 3'b010;
    tgt_r_data_i[1] = 32'h0000_0A08;
    #2;
    chk("full_rdata3", core_rdata_o, 32'h0000_0A08);
    cyc();
    idle();
    #2;
    chk("full_proto", 32'(proto_err_o), 32'd0);

    // putchar write.
    cyc();
    req(1'b1, 32'h8000_0004, 32'h0000_0041, 3'b000);
    #2;
    chk("putc_gnt",     32'(core_gnt_o), 32'd1);
    chk("putc_tgt_req", 32'(tgt_req_o), 32'b000);
    cyc();
    idle();
    #2;
    chk("putc_valid",  32'(putchar_valid_o), 32'd1);
    chk("putc_char",   32'(putchar_o), 32'h41);
    chk("putc_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("putc_err",    32'(core_err_o), 32'd0);
    cyc();
    #2;
    chk("putc_valid_off", 32'(putchar_valid_o), 32'd0);
    chk("putc_rvalid_off", 32'(core_rvalid_o), 32'd0);

    // Exit write, then a blocked and a granted unmapped internal read.
    cyc();
    req(1'b1, 32'h8000_0000, 32'h0, 3'b000);
    #2;
    chk("exit_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    req(1'b0, 32'h8000_0008, 32'h0, 3'b000);
    #2;
    chk("exit_valid",   32'(exit_valid_o), 32'd1);
    chk("exit_code",    exit_code_o, 32'h0);
    chk("exit_rvalid",  32'(core_rvalid_o), 32'd1);
    chk("int_busy_gnt", 32'(core_gnt_o), 32'd0);
    cyc();
    #2;
    chk("bad_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    req(1'b0, 32'h8000_0000, 32'h0, 3'b000);
    #2;
    chk("bad_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("bad_err",    32'(core_err_o), 32'd1);
    chk("bad_rdata",  core_rdata_o, 32'hDEAD_BEEF);
    cyc();
    #2;
    chk("exrd_gnt", 32'(core_gnt_o), 32'd1);
    cyc();
    idle();
    #2;
    chk("exrd_rdata", core_rdata_o, 32'h0);
    chk("exrd_err",   32'(core_err_o), 32'd0);
    cyc();

    // Reset with two stack reads outstanding, then a stale response.
    req(1'b0, 32'h0000_0300, 32'h0, 3'b010);
    cyc();
    req(1'b0, 32'h0000_0304, 32'h0, 3'b010);
    cyc();
    idle();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    tgt_rvalid_i    = 3'b010;
    tgt_r_data_i[1] = 32'h5555_5555;
    #2;
    chk("late_rvalid", 32'(core_rvalid_o), 32'd0);
    chk("late_rdata",  core_rdata_o, 32'h0);
    cyc();
    idle();
    #2;
    chk("late_proto",      32'(proto_err_o), 32'd1);
    chk("late_exit_valid", 32'(exit_valid_o), 32'd0);
    chk("late_exit_code",  exit_code_o, 32'hFFFF_FFFF);
    chk("late_putc_valid", 32'(putchar_valid_o), 32'd0);
    chk("late_putc",       32'(putchar_o), 32'd0);
    chk("late_gnt",        32'(core_gnt_o), 32'd0);
    chk("late_err",        32'(core_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
